// File: rtl/cpu_txn_source.sv
// -----------------------------------------------------------------------------
// cpu_txn_source
//
// Per-CPU transaction generator feeding the multisim client send path. Emits
// NUM_TXN 64-bit transactions {cpu_index, seq} on a valid/ready interface. A
// small first-word-fall-through FIFO decouples generation from downstream
// back-pressure. transactions_done rises once every transaction has been
// accepted and stays high until reset.
//
// Parameters:
//   NUM_TXN     number of transactions to emit (0 .. 2^32-1)
//   FIFO_DEPTH  output FIFO entries, power of two, >= 2
//   GAP_CYCLES  idle cycles inserted after each push (0 .. 255)
//
// Ports:
//   clk                in   rising-edge clock
//   rst                in   asynchronous active-high reset
//   cpu_index    [31:0] in   CPU identifier, sampled at each push
//   data_rdy           in   downstream ready
//   data_vld           out  transaction valid (FIFO not empty)
//   data         [63:0] out  head-of-FIFO payload, zero while empty
//   transactions_done  out  sticky: all NUM_TXN transactions accepted
//   fifo_level         out  FIFO occupancy (debug)
// -----------------------------------------------------------------------------
module cpu_txn_source #(
   parameter logic [31:0] NUM_TXN    = 32'd16,
   parameter int          FIFO_DEPTH = 4,
   parameter int          GAP_CYCLES = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   cpu_index,
   input  logic                          data_rdy,
   output logic                          data_vld,
   output logic [63:0]                   data,
   output logic                          transactions_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int              PW       = $clog2(FIFO_DEPTH);
   localparam int              LW       = PW + 1;
   localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [7:0]      GAP_LEN  = GAP_CYCLES[7:0];

   typedef enum logic [1:0] {
      GEN   = 2'd0,
      GAP   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [31:0]     seq;
   logic [31:0]     acc;
   logic [7:0]      gap_cnt;
   logic            done;

   logic [63:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [LW-1:0]   level;

   logic            full;
   logic            pop;
   logic            push;
   logic            gap_load;
   logic            last_push;
   logic            done_set;

   // Push is refused whenever the FIFO is full, even if a pop frees a slot on
   // the same edge: there is no bypass path from push to pop.
   assign full      = (level == FULL_LVL);
   assign pop       = (level != '0) && data_rdy;

   // 33-bit compare so seq+1 cannot alias when NUM_TXN is near 2^32-1.
   assign last_push = (({1'b0, seq} + 33'd1) == {1'b0, NUM_TXN});

   // Completion needs every transaction both generated and accepted with the
   // FIFO empty; for NUM_TXN == 0 this holds straight out of reset.
   assign done_set  = (seq == NUM_TXN) && (acc == NUM_TXN) && (level == '0);

   // ---------------------------------------------------------------------------
   // Generator FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= GEN;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Generator FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         GEN: begin
            if (NUM_TXN == 32'd0) begin
               state_nxt = DRAIN;
            end else if (!full) begin
               if (last_push) begin
                  state_nxt = DRAIN;
               end else if (GAP_LEN != 8'd0) begin
                  state_nxt = GAP;
               end
            end
         end
         GAP: begin
            // The counter is loaded with GAP_LEN, so leaving on the cycle it
            // reads 1 gives exactly GAP_LEN idle cycles before the next push.
            if (gap_cnt <= 8'd1) begin
               state_nxt = GEN;
            end
         end
         DRAIN: begin
            if (acc == NUM_TXN) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = GEN;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Generator FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      push     = 1'b0;
      gap_load = 1'b0;
      if ((state == GEN) && !full && (NUM_TXN != 32'd0)) begin
         push     = 1'b1;
         gap_load = !last_push && (GAP_LEN != 8'd0);
      end
   end

   // ---------------------------------------------------------------------------
   // Counters and completion flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq     <= '0;
         acc     <= '0;
         gap_cnt <= '0;
         done    <= 1'b0;
      end else begin
         if (push) begin
            seq <= seq + 32'd1;
         end
         if (pop) begin
            acc <= acc + 32'd1;
         end
         if (gap_load) begin
            gap_cnt <= GAP_LEN;
         end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
            gap_cnt <= gap_cnt - 8'd1;
         end
         if (done_set) begin
            done <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO control: pointers wrap naturally at the power-of-two depth
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage: payload is not reset; empty slots are masked at the output
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cpu_index, seq};
      end
   end

   assign data_vld          = (level != '0);
   assign data              = data_vld ? mem[rd_ptr] : 64'd0;
   assign transactions_done = done;
   assign fifo_level        = level;

endmodule

// File: tb/tb_cpu_txn_source.sv
// -----------------------------------------------------------------------------
// tb_cpu_txn_source
//
// Four generator instances with different parameter sets share clock and
// reset; each has its own ready and cpu_index. A transaction-level reference
// model (occupancy, pushes issued, accepts, cooldown) predicts every output
// each cycle from the generator rules.
//   dut 0: NUM_TXN=4,  GAP=0
//   dut 1: NUM_TXN=16, GAP=0
//   dut 2: NUM_TXN=3,  GAP=3
//   dut 3: NUM_TXN=0
// -----------------------------------------------------------------------------
module tb_cpu_txn_source;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu  [4];
   logic        rdy  [4];
   logic        vld  [4];
   logic [63:0] dat  [4];
   logic        done [4];
   logic [2:0]  lvl  [4];

   always #5 clk = ~clk;

   cpu_txn_source #(.NUM_TXN(32'd4), .FIFO_DEPTH(D), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .cpu_index(cpu[0]), .data_rdy(rdy[0]),
      .data_vld(vld[0]), .data(dat[0]), .transactions_done(done[0]), .fifo_level(lvl[0]));
   cpu_txn_source #(.NUM_TXN(32'd16), .FIFO_DEPTH(D), .GAP_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .cpu_index(cpu[1]), .data_rdy(rdy[1]),
      .data_vld(vld[1]), .data(dat[1]), .transactions_done(done[1]), .fifo_level(lvl[1]));
   cpu_txn_source #(.NUM_TXN(32'd3), .FIFO_DEPTH(D), .GAP_CYCLES(3)) u_dut2 (
      .clk(clk), .rst(rst), .cpu_index(cpu[2]), .data_rdy(rdy[2]),
      .data_vld(vld[2]), .data(dat[2]), .transactions_done(done[2]), .fifo_level(lvl[2]));
   cpu_txn_source #(.NUM_TXN(32'd0), .FIFO_DEPTH(D), .GAP_CYCLES(0)) u_dut3 (
      .clk(clk), .rst(rst), .cpu_index(cpu[3]), .data_rdy(rdy[3]),
      .data_vld(vld[3]), .data(dat[3]), .transactions_done(done[3]), .fifo_level(lvl[3]));

   int unsigned nt [4] = '{4, 16, 3, 0};
   int unsigned gp [4] = '{0, 0, 3, 0};

   // Reference model state per instance.
   int unsigned m_l   [4];   // occupancy
   int unsigned m_p   [4];   // transactions generated
   int unsigned m_acc [4];   // transactions accepted
   int unsigned m_cd  [4];   // idle cycles still owed before next generation
   bit          m_done[4];

   int checks   = 0;
   int failures = 0;
   int maxl     = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_l[i] = 0; m_p[i] = 0; m_acc[i] = 0; m_cd[i] = 0; m_done[i] = 1'b0;
      end
   endtask

   // One clock edge of the transaction-level behaviour for instance i.
   task automatic model_step(input int i, input bit r);
      bit take, gen, fin;
      take = (m_l[i] > 0) && r;
      gen  = (m_p[i] < nt[i]) && (m_l[i] < D) && (m_cd[i] == 0);
      fin  = m_done[i] || ((m_acc[i] == nt[i]) && (m_l[i] == 0) && (m_p[i] == nt[i]));
      if (take) m_acc[i]++;
      m_l[i] = m_l[i] + int'(gen) - int'(take);
      if (gen) begin
         m_p[i]++;
         m_cd[i] = (m_p[i] < nt[i]) ? gp[i] : 0;
      end else if (m_cd[i] > 0) begin
         m_cd[i]--;
      end
      m_done[i] = fin;
   endtask

   task automatic check_all(input string ph);
      logic [63:0] exp_data;
      for (int i = 0; i < 4; i++) begin
         // The head of an in-order FIFO always carries the next unaccepted seq.
         exp_data = (m_l[i] > 0) ? {cpu[i], m_acc[i]} : 64'd0;
         chk($sformatf("%s_vld%0d", ph, i),  64'(vld[i]),  64'(m_l[i] > 0));
         chk($sformatf("%s_data%0d", ph, i), dat[i],       exp_data);
         chk($sformatf("%s_lvl%0d", ph, i),  64'(lvl[i]),  64'(m_l[i]));
         chk($sformatf("%s_done%0d", ph, i), 64'(done[i]), 64'(m_done[i]));
      end
   endtask

   function automatic bit pick(input int mode, input int i, input int c);
      if (mode == 0) begin
         if (i == 1) return (c < 10) ? 1'b0 : (c % 2 == 0);
         if (i == 3) return 1'($urandom % 2);
         return 1'b1;
      end
      return ($urandom % 4) != 0;
   endfunction

   // Called just after a falling edge; drives ready, advances the model, and
   // checks outputs at the next falling edge. Optionally stops once instance 1
   // presents seq 5 at its head.
   task automatic run(input int mode, input int ncyc, input bit stop5, output bit hit);
      hit = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         if (stop5 && (m_acc[1] == 5) && (m_l[1] > 0)) begin
            hit = 1'b1;
            break;
         end
         for (int i = 0; i < 4; i++) begin
            rdy[i] = pick(mode, i, c);
            model_step(i, rdy[i]);
         end
         @(negedge clk);
         check_all($sformatf("m%0d_c%0d", mode, c));
         if (int'(lvl[1]) > maxl) maxl = int'(lvl[1]);
      end
   endtask

   initial begin
      bit hit;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) rdy[i] = 1'b0;
      cpu[0] = 32'd3;
      cpu[1] = $urandom;
      cpu[2] = $urandom;
      cpu[3] = $urandom;
      model_reset();
      #2;
      check_all("rst0");
      @(negedge clk);
      rst = 1'b0;

      // Directed patterns: constant ready, 10-cycle stall then 1/0 toggling,
      // gapped generation, and the empty stream.
      run(0, 80, 1'b0, hit);
      chk("sat_level", 64'(maxl), 64'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("end0_done%0d", i), 64'(done[i]), 64'd1);

      // Asynchronous reset after completion: outputs must clear with no edge.
      #2 rst = 1'b1;
      #1 model_reset();
      check_all("arst_done");
      for (int i = 1; i < 4; i++) cpu[i] = $urandom;
      @(negedge clk);
      rst = 1'b0;

      // Random ready until instance 1 shows seq 5, then reset mid-stream.
      run(1, 100, 1'b1, hit);
      chk("reach_seq5", 64'(hit), 64'd1);
      #3 rst = 1'b1;
      #1 model_reset();
      check_all("arst_mid");
      @(negedge clk);
      check_all("rst_hold");
      rst = 1'b0;

      // Restart from seq 0 with random back-pressure through to completion.
      run(1, 200, 1'b0, hit);
      for (int i = 0; i < 4; i++) chk($sformatf("end1_done%0d", i), 64'(done[i]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_txn_source.md
Name: cpu_txn_source

Overview:
- Per-CPU transaction generator that sits directly upstream of the multisim client send path.
- Produces a fixed-length stream of 64-bit transactions on a valid/ready interface (data_vld/data_rdy/data).
- Buffers transactions in a small FIFO so that client back-pressure (data_rdy low while the server is busy) does not stall generation.
- Raises transactions_done once every transaction has been accepted downstream, so the testbench can end the simulation.

Parameters:
- NUM_TXN, 16: number of transactions to emit. Legal range 0 .. 2^32-1.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of 2, at least 2.
- GAP_CYCLES, 0: idle cycles the generator inserts after each push. Legal range 0..255.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- cpu_index  input  32  CPU identifier; quasi-static, sampled at each push
- data_rdy  input  1  downstream ready
- data_vld  output  1  transaction valid
- data  output  64  transaction payload
- transactions_done  output  1  all NUM_TXN transactions accepted; sticky
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy (debug)

Behaviour:
- Interface: single clock clk. Reset rst is asynchronous and active-high: assertion clears all state immediately; release takes effect at the next rising edge.
- Reset values:
  - data_vld=0, data=0, transactions_done=0, fifo_level=0.
  - Internal push count seq=0, accept count acc=0, gap counter=0, FSM=GEN.
- Payload: data = {cpu_index[31:0], seq[31:0]}, captured at push time. seq starts at 0 and increments by 1 per push. No wrap within the legal NUM_TXN range.
- Generator FSM:
  - GEN: push when FIFO not full. After a push:
    - seq+1 == NUM_TXN -> DRAIN
    - else GAP_CYCLES > 0 -> GAP, load gap counter = GAP_CYCLES
    - else stay in GEN.
    - FIFO full -> hold in GEN, no push.
  - GAP: decrement gap counter each cycle; on reaching 1 -> GEN. No push while in GAP.
  - DRAIN: no pushes. When acc == NUM_TXN -> DONE.
  - DONE: terminal until reset.
  - NUM_TXN == 0: GEN goes to DRAIN on the first edge after reset with no push; DONE and transactions_done follow.
- FIFO:
  - Registered, first-word-fall-through.
  - data_vld = (fifo_level != 0); data = head entry.
  - Pop on an edge where data_vld && data_rdy.
  - Push and pop in the same cycle are both honoured; level unchanged.
  - Push is blocked when level == FIFO_DEPTH, even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the first push occurs at the first rising edge after rst release. data_vld is high after that edge, carrying seq 0.
- Handshake rules:
  - While data_vld=1 and data_rdy=0, data and data_vld hold stable.
  - data_vld never drops without an accept.
  - data_rdy may be high while data_vld=0; no effect.
- Completion:
  - acc increments on every accept.
  - transactions_done is registered: it goes high on the edge after acc reaches NUM_TXN and FIFO is empty.
  - transactions_done stays high until rst. data_vld=0 thereafter.
- Reset mid-stream: all counters and FIFO contents are discarded. After release, the stream restarts at seq 0.
- No X on outputs after reset, regardless of data_rdy.

Test Plan:
- NUM_TXN=4, GAP=0, data_rdy=1 constant, cpu_index=3:
  - data = 0x00000003_00000000 .. 0x00000003_00000003 on 4 consecutive cycles.
  - transactions_done high 1 cycle after the 4th accept.
- NUM_TXN=16, FIFO_DEPTH=4, data_rdy=0 for 10 cycles then 1:
  - fifo_level saturates at 4.
  - data holds 0x..._00000000 stable throughout.
  - All 16 seq values arrive in order, none lost or duplicated.
- data_rdy toggling 1,0,1,0 (mimics client one-cycle stall):
  - Each seq is accepted exactly once; data stable in cycles with data_rdy=0.
- GAP_CYCLES=3, NUM_TXN=3, data_rdy=1:
  - Pushes occur 4 cycles apart; data_vld pulses 1 cycle each.
  - transactions_done after the 3rd accept.
- NUM_TXN=0:
  - data_vld never asserts.
  - transactions_done=1 within 3 cycles of reset release.
- Assert rst asynchronously mid-stream at seq 5:
  - Outputs clear immediately without a clock.
  - After release, the first data carries seq 0; transactions_done=0.
